dsp48a1_dot_seq: RTL and testbench

Operand sequencer that sits directly upstream of the DSP48A1 slice and drives its A/B/C/OPMODE ports to compute biased dot products (sum of A_i*B_i plus a 48-bit bias) over variable-length operand vectors. Operands arrive on a valid/ready stream and the final accumulator value is captured from the slice's P port. The result is returned on a second valid/ready stream together with a beat count. The slice instance is configured OPMODEREG=1, MREG=1, PREG=1, CREG=1, A0/A1/B0/B1/DREG=0, B_INPUT="DIRECT", CARRYINSEL="OPMODE5".

---
 rtl/dsp48a1_dot_seq_if.sv | 27 ++
 rtl/dsp48a1_dot_seq.sv | 116 +++++++++++
 tb/tb_dsp48a1_dot_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp48a1_dot_seq_if.sv
// Operand and result streams of the DSP48A1 dot-product sequencer.
// master = operand source / result sink, slave = sequencer.
interface dsp48a1_dot_seq_if #(
    parameter int unsigned LEN_W = 4
);
    logic             s_valid;
    logic             s_ready;
    logic [17:0]      s_a;
    logic [17:0]      s_b;
    logic             s_last;
    logic [47:0]      bias;
    logic             m_valid;
    logic             m_ready;
    logic [47:0]      m_result;
    logic [LEN_W-1:0] m_count;
    logic             m_err;

    modport master (
        output s_valid, s_a, s_b, s_last, bias, m_ready,
        input  s_ready, m_valid, m_result, m_count, m_err
    );

    modport slave (
        input  s_valid, s_a, s_b, s_last, bias, m_ready,
        output s_ready, m_valid, m_result, m_count, m_err
    );
endinterface

// File: rtl/dsp48a1_dot_seq.sv
// Sequences operand beats into a DSP48A1 slice (OPMODEREG/MREG/PREG/CREG=1) to form
// BIAS + sum(A*B) per vector, then returns the captured P with a saturating beat count.
module dsp48a1_dot_seq #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    dsp48a1_dot_seq_if.slave   bus,
    output logic [17:0]        dsp_a,
    output logic [17:0]        dsp_b,
    output logic [17:0]        dsp_d,
    output logic [47:0]        dsp_c,
    output logic [7:0]         dsp_opmode,
    output logic               dsp_carryin,
    input  logic [47:0]        dsp_p
);
    localparam int unsigned DCNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(LATENCY - 1);
    localparam logic [LEN_W-1:0]  CNT_MAX    = '1;

    localparam logic [7:0] OP_FIRST = 8'h0D;
    localparam logic [7:0] OP_ACCUM = 8'h09;
    localparam logic [7:0] OP_HOLD  = 8'h08;
    localparam logic [7:0] OP_CLEAR = 8'h00;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

    state_t             state;
    logic               s_ready;
    logic               accept;
    logic [DCNT_W-1:0]  drain_cnt;
    logic [LEN_W-1:0]   count;
    logic               err;
    logic               m_valid;
    logic [47:0]        m_result;

    assign dsp_a       = bus.s_a;
    assign dsp_b       = bus.s_b;
    assign dsp_c       = bus.bias;
    assign dsp_d       = '0;
    assign dsp_carryin = 1'b0;

    assign bus.s_ready  = s_ready;
    assign bus.m_valid  = m_valid;
    assign bus.m_result = m_result;
    assign bus.m_count  = count;
    assign bus.m_err    = err;

    // Slice control follows the handshake in the same cycle so M/C/OPMODE latch together.
    always_comb begin
        s_ready    = rst_n && ((state == IDLE) || (state == ACC));
        accept     = s_ready && bus.s_valid;
        dsp_opmode = OP_CLEAR;
        unique case (state)
            IDLE:    dsp_opmode = accept ? OP_FIRST : OP_CLEAR;
            ACC:     dsp_opmode = accept ? OP_ACCUM : OP_HOLD;
            default: dsp_opmode = OP_HOLD;
        endcase
        if (!rst_n) begin
            dsp_opmode = OP_CLEAR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain_cnt <= '0;
            count     <= '0;
            err       <= 1'b0;
            m_valid   <= 1'b0;
            m_result  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        count     <= LEN_W'(1);
                        err       <= 1'b0;
                        drain_cnt <= '0;
                        state     <= bus.s_last ? DRAIN : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        // Overlong vectors keep accumulating; only the count saturates.
                        if (count == CNT_MAX) begin
                            err <= 1'b1;
                        end else begin
                            count <= count + LEN_W'(1);
                        end
                        if (bus.s_last) begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        m_result <= dsp_p;
                        m_valid  <= 1'b1;
                        state    <= OUT;
                    end else begin
                        drain_cnt <= drain_cnt + DCNT_W'(1);
                    end
                end
                OUT: begin
                    if (bus.m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp48a1_dot_seq.sv
// Bench for dsp48a1_dot_seq: behavioural DSP48A1 slice plus a dot-product reference model.
module tb_dsp48a1_dot_seq;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned LEN_W   = 2;
    localparam int          CNT_MAX = (1 << LEN_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [47:0] dsp_c;
    logic [7:0]  dsp_opmode;
    logic        dsp_carryin;
    logic [47:0] dsp_p;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int acc_edge;
    int first_edge;
    int gap_total;

    dsp48a1_dot_seq_if #(.LEN_W(LEN_W)) bus();

    dsp48a1_dot_seq #(.LATENCY(LATENCY), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dsp_a       (dsp_a),
        .dsp_b       (dsp_b),
        .dsp_d       (dsp_d),
        .dsp_c       (dsp_c),
        .dsp_opmode  (dsp_opmode),
        .dsp_carryin (dsp_carryin),
        .dsp_p       (dsp_p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slice model: A/B unregistered, M/C/OPMODE registered, P registered.
    logic [7:0]         op_r = '0;
    logic signed [35:0] m_r  = '0;
    logic [47:0]        c_r  = '0;
    logic [47:0]        p_r  = '0;
    logic [47:0]        x_mux, z_mux;

    always_comb begin
        x_mux = (op_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0;
        case (op_r[3:2])
            2'b11:   z_mux = c_r;
            2'b10:   z_mux = p_r;
            default: z_mux = 48'd0;
        endcase
    end

    always @(posedge clk) begin
        op_r <= dsp_opmode;
        m_r  <= $signed(dsp_a) * $signed(dsp_b);
        c_r  <= dsp_c;
        p_r  <= z_mux + x_mux;
    end
    assign dsp_p = p_r;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    function automatic logic [47:0] ref_dot(input logic [17:0] av[$], input logic [17:0] bv[$],
                                            input logic [47:0] bi);
        logic [47:0] acc = bi;
        for (int i = 0; i < av.size(); i++) begin
            longint p = longint'($signed(av[i])) * longint'($signed(bv[i]));
            acc = acc + 48'(p);
        end
        return acc;
    endfunction

    // Called and returns just after a falling edge.
    task automatic send_beats(input logic [17:0] av[$], input logic [17:0] bv[$],
                              input logic [47:0] bi, input int gap_at, input int gap_len,
                              input bit rand_gaps, input bit no_last);
        gap_total = 0;
        for (int i = 0; i < av.size(); i++) begin
            int g = (i == gap_at) ? gap_len : 0;
            int t = 0;
            if (rand_gaps && i > 0 && $urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
            if (g > 0) begin
                bus.s_valid = 1'b0;
                bus.s_last  = 1'($urandom);
                repeat (g) @(negedge clk);
                gap_total += g;
            end
            bus.s_valid = 1'b1;
            bus.s_a     = av[i];
            bus.s_b     = bv[i];
            bus.s_last  = (i == av.size() - 1) && !no_last;
            bus.bias    = (i == 0) ? bi : 48'({$urandom, $urandom});
            while (!bus.s_ready && t < 64) begin
                @(negedge clk);
                t++;
            end
            check("s_ready_beat", 64'(bus.s_ready), 64'd1);
            check("dsp_a_copy", 64'(dsp_a), 64'(av[i]));
            check("dsp_b_copy", 64'(dsp_b), 64'(bv[i]));
            if (i == 0) begin
                check("dsp_c_copy", 64'(dsp_c), 64'(bi));
                first_edge = cyc + 1;
            end
            acc_edge = cyc + 1;
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'($urandom);
        check("beat_span", 64'(acc_edge - first_edge), 64'(av.size() - 1 + gap_total));
    endtask

    task automatic collect(input logic [47:0] exp_res, input int n_beats, input int rdy_dly);
        int t = 0;
        int exp_cnt = (n_beats > CNT_MAX) ? CNT_MAX : n_beats;
        logic exp_err = (n_beats > CNT_MAX);
        while (!bus.m_valid && t < 64) begin
            check("s_ready_drain", 64'(bus.s_ready), 64'd0);
            @(negedge clk);
            t++;
        end
        check("m_valid_latency", 64'(cyc - acc_edge), 64'(LATENCY));
        for (int k = 0; k < rdy_dly; k++) begin
            check("hold_m_valid", 64'(bus.m_valid), 64'd1);
            check("hold_m_result", 64'(bus.m_result), 64'(exp_res));
            check("hold_s_ready", 64'(bus.s_ready), 64'd0);
            @(negedge clk);
        end
        check("m_result", 64'(bus.m_result), 64'(exp_res));
        check("m_count", 64'(bus.m_count), 64'(exp_cnt));
        check("m_err", 64'(bus.m_err), 64'(exp_err));
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        check("m_valid_drop", 64'(bus.m_valid), 64'd0);
        check("s_ready_idle", 64'(bus.s_ready), 64'd1);
    endtask

    task automatic run_vec(input logic [17:0] av[$], input logic [17:0] bv[$], input logic [47:0] bi,
                           input int gap_at, input int gap_len, input bit rand_gaps, input int rdy_dly);
        send_beats(av, bv, bi, gap_at, gap_len, rand_gaps, 1'b0);
        collect(ref_dot(av, bv, bi), av.size(), rdy_dly);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
        check({tag, "_m_valid"}, 64'(bus.m_valid), 64'd0);
        check({tag, "_m_result"}, 64'(bus.m_result), 64'd0);
        check({tag, "_m_count"}, 64'(bus.m_count), 64'd0);
        check({tag, "_m_err"}, 64'(bus.m_err), 64'd0);
        check({tag, "_opmode"}, 64'(dsp_opmode), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [17:0] av[$];
        logic [17:0] bv[$];
        logic [17:0] mn = 18'h20000;

        bus.s_valid = 1'b1;
        bus.s_a     = '0;
        bus.s_b     = '0;
        bus.s_last  = 1'b0;
        bus.bias    = '0;
        bus.m_ready = 1'b0;
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        av = {18'(3), 18'(5), 18'(-2)};
        bv = {18'(4), 18'(6), 18'(7)};
        run_vec(av, bv, 48'd10, -1, 0, 1'b0, 0);
        check("tp_basic", 64'(bus.m_result), 64'd38);
        run_vec(av, bv, 48'd10, 1, 2, 1'b0, 0);
        check("tp_gap", 64'(bus.m_result), 64'd38);

        av = {mn};
        bv = {mn};
        run_vec(av, bv, 48'd0, -1, 0, 1'b0, 0);
        check("tp_minsq", 64'(bus.m_result), 64'd17179869184);
        av = {mn, mn};
        bv = {mn, mn};
        run_vec(av, bv, 48'd0, -1, 0, 1'b0, 5);
        check("tp_minsq2", 64'(bus.m_result), 64'd34359738368);

        av = {18'(1)};
        bv = {18'(1)};
        run_vec(av, bv, 48'hFFFF_FFFF_FFFF, -1, 0, 1'b0, 0);
        check("tp_bias_neg", 64'(bus.m_result), 64'd0);

        av = {18'(1), 18'(1), 18'(1), 18'(1)};
        bv = {18'(1), 18'(1), 18'(1), 18'(1)};
        run_vec(av, bv, 48'd0, -1, 0, 1'b0, 0);
        check("tp_sat_err", 64'(bus.m_err), 64'd1);
        av = {18'(7)};
        bv = {18'(9)};
        run_vec(av, bv, 48'd0, -1, 0, 1'b0, 0);
        check("tp_err_clear", 64'(bus.m_err), 64'd0);

        // Abort mid-vector with an asynchronous reset.
        av = {18'(100), 18'(200)};
        bv = {18'(300), 18'(400)};
        send_beats(av, bv, 48'd12345, -1, 0, 1'b0, 1'b1);
        rst_n = 1'b0;
        bus.s_valid = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        check("mid_rst_s_ready_held", 64'(bus.s_ready), 64'd0);
        @(negedge clk);
        bus.s_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        av = {18'(2)};
        bv = {18'(3)};
        run_vec(av, bv, 48'd1, -1, 0, 1'b0, 0);
        check("tp_after_rst", 64'(bus.m_result), 64'd7);

        for (int v = 0; v < 40; v++) begin
            int n = $urandom_range(1, 6);
            av.delete();
            bv.delete();
            for (int i = 0; i < n; i++) begin
                av.push_back(18'($urandom));
                bv.push_back(18'($urandom));
            end
            run_vec(av, bv, 48'({$urandom, $urandom}), -1, 0, 1'b1, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
